// File: rtl/stmt_sel_burst_encoder.sv
// Request arbiter that encodes the winning line as a select code and streams it as a BURST-beat valid/ready burst.
// Optional macro STMT_SEL_BURST_ENCODER_RR_EN switches fixed lowest-index priority to round-robin arbitration.
module stmt_sel_burst_encoder #(
   parameter int NUM_REQ = 3,
   parameter int SEL_W   = 2,
   parameter int BURST   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_last,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] done,
   output logic               busy
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

   state_t             state;
   logic [3:0]         cnt;
   logic [SEL_W-1:0]   win_idx;
   logic               win_any;
   logic [NUM_REQ-1:0] win_onehot;

`ifdef STMT_SEL_BURST_ENCODER_RR_EN
   logic [SEL_W-1:0]   last_idx;
   int                 rank;
   int                 best_rank;

   // Rank 0 is the line just after the last completed grant; the lowest-ranked set bit wins.
   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      win_idx   = '0;
      win_any   = 1'b0;
      rank      = 0;
      best_rank = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         rank = (i + 2 * NUM_REQ - int'(last_idx) - 1) % NUM_REQ;
         if (req[i] && (rank < best_rank)) begin
            best_rank = rank;
            win_idx   = SEL_W'(i);
            win_any   = 1'b1;
         end
      end
   end
`else
   // Scanning downward lets the lowest set index overwrite the others.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_idx = SEL_W'(i);
            win_any = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_onehot[i] = win_any && (win_idx == SEL_W'(i));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_sel   <= '0;
         grant     <= '0;
         done      <= '0;
         cnt       <= '0;
`ifdef STMT_SEL_BURST_ENCODER_RR_EN
         last_idx  <= SEL_W'(NUM_REQ - 1);
`endif
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (win_any) begin
                  out_sel   <= win_idx;
                  grant     <= win_onehot;
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (cnt == LAST_BEAT) begin
                     done      <= grant;
                     grant     <= '0;
                     out_sel   <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= IDLE;
`ifdef STMT_SEL_BURST_ENCODER_RR_EN
                     last_idx  <= out_sel;
`endif
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Decoded from registers only, so it cannot glitch on input activity.
   assign out_last = (state == SEND) && (cnt == LAST_BEAT);

endmodule

// File: tb/tb_stmt_sel_burst_encoder.sv
// Randomized bench for stmt_sel_burst_encoder: a default-BURST instance and a BURST=1 instance against a beat-level reference model.
module tb_stmt_sel_burst_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = '0;
   logic       ready = 1'b0;
   logic [2:0] req1 = '0;
   logic       ready1 = 1'b0;

   logic       valid_a, last_a, busy_a;
   logic [1:0] sel_a;
   logic [2:0] grant_a, done_a;
   logic       valid_b, last_b, busy_b;
   logic [1:0] sel_b;
   logic [2:0] grant_b, done_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: unit 0 is the BURST=3 instance, unit 1 the BURST=1 instance.
   int         blen   [2] = '{3, 1};
   bit         m_send [2];
   int         m_beat [2];
   int         m_code [2];
   int         m_prev [2];
   logic [2:0] m_done [2];

   stmt_sel_burst_encoder dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .out_valid(valid_a), .out_ready(ready),
      .out_sel(sel_a), .out_last(last_a), .grant(grant_a), .done(done_a), .busy(busy_a)
   );

   stmt_sel_burst_encoder #(.NUM_REQ(3), .SEL_W(2), .BURST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req1), .out_valid(valid_b), .out_ready(ready1),
      .out_sel(sel_b), .out_last(last_b), .grant(grant_b), .done(done_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int pick(input int u, input logic [2:0] r);
`ifdef STMT_SEL_BURST_ENCODER_RR_EN
      for (int k = 1; k <= 3; k++) begin
         if (r[(m_prev[u] + k) % 3]) return (m_prev[u] + k) % 3;
      end
`else
      for (int k = 0; k < 3; k++) begin
         if (r[k]) return k;
      end
`endif
      return 0;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_send[u] = 1'b0;
         m_beat[u] = 0;
         m_code[u] = 0;
         m_prev[u] = 2;
         m_done[u] = '0;
      end
   endtask

   task automatic model_step(input int u, input logic [2:0] r, input logic rdy);
      logic [2:0] d;
      d = '0;
      if (!m_send[u]) begin
         if (r != 3'b000) begin
            m_code[u] = pick(u, r);
            m_beat[u] = 0;
            m_send[u] = 1'b1;
         end
      end else if (rdy) begin
         if (m_beat[u] == blen[u] - 1) begin
            d         = 3'b001 << m_code[u];
            m_prev[u] = m_code[u];
            m_send[u] = 1'b0;
         end else begin
            m_beat[u]++;
         end
      end
      m_done[u] = d;
   endtask

   task automatic compare(input int u, input logic v, input logic [1:0] s, input logic l,
                          input logic [2:0] g, input logic [2:0] d, input logic b);
      string p;
      p = (u == 0) ? "a" : "b";
      check({p, ".valid"}, 32'(v), 32'(m_send[u]));
      check({p, ".busy"},  32'(b), 32'(m_send[u]));
      check({p, ".sel"},   32'(s), m_send[u] ? 32'(m_code[u]) : 32'd0);
      check({p, ".grant"}, 32'(g), m_send[u] ? (32'd1 << m_code[u]) : 32'd0);
      check({p, ".last"},  32'(l), 32'(m_send[u] && (m_beat[u] == blen[u] - 1)));
      check({p, ".done"},  32'(d), 32'(m_done[u]));
   endtask

   // Inputs are applied at the falling edge, the model advances at the rising edge, outputs are compared at the next falling edge.
   task automatic step(input logic [2:0] r, input logic rdy);
      req   = r;
      ready = rdy;
      @(posedge clk);
      model_step(0, req, ready);
      model_step(1, req1, ready1);
      @(negedge clk);
      compare(0, valid_a, sel_a, last_a, grant_a, done_a, busy_a);
      compare(1, valid_b, sel_b, last_b, grant_b, done_b, busy_b);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      compare(0, valid_a, sel_a, last_a, grant_a, done_a, busy_a);
      compare(1, valid_b, sel_b, last_b, grant_b, done_b, busy_b);
      rst_n = 1'b1;

      // Idle with no requests.
      repeat (5) step(3'b000, 1'b1);

      // Priority and back-to-back bursts; the BURST=1 instance sees all lines held.
      req1   = 3'b111;
      ready1 = 1'b1;
      repeat (10) step(3'b110, 1'b1);
      repeat (2) step(3'b000, 1'b1);

      // Backpressure on beat 2 of a code-0 burst.
      step(3'b001, 1'b1);
      step(3'b000, 1'b1);
      repeat (4) step(3'b000, 1'b0);
      repeat (4) step(3'b000, 1'b1);

      // Request withdrawn after one cycle.
      step(3'b100, 1'b1);
      repeat (5) step(3'b000, 1'b1);

      // Asynchronous reset between beats 1 and 2.
      step(3'b010, 1'b1);
      step(3'b000, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst.valid", 32'(valid_a), 32'd0);
      check("rst.grant", 32'(grant_a), 32'd0);
      check("rst.busy",  32'(busy_a),  32'd0);
      check("rst.sel",   32'(sel_a),   32'd0);
      model_reset();
      @(negedge clk);
      compare(0, valid_a, sel_a, last_a, grant_a, done_a, busy_a);
      rst_n = 1'b1;
      step(3'b001, 1'b1);
      repeat (4) step(3'b000, 1'b1);

      // Random traffic on both instances.
      for (int n = 0; n < 400; n++) begin
         req1   = 3'($urandom_range(0, 7));
         ready1 = ($urandom_range(0, 3) != 0);
         step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stmt_sel_burst_encoder.md
Name: stmt_sel_burst_encoder

Overview:
- Sequential counterpart to the case/casez selector fixtures: receives request lines, picks a winner and encodes it onto a select code (`out_sel`).
- Streams that code as a fixed-length burst over a valid/ready interface.
- Consumers are case-style mux selectors: code i selects input i.
- Lives in the convert fixture set. Exercises FSM, counter and handshake lowering with casez-priority and repeat-equivalent sequential logic.

Parameters:
- NUM_REQ, 3, number of request lines. Range 2..8.
- SEL_W, 2, select code width. Must satisfy 2**SEL_W >= NUM_REQ.
- BURST, 3, beats per grant. Range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request lines; bit i requests code i.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_sel  output  SEL_W  encoded select code of current grant.
- out_last  output  1  final beat of burst (qualified by out_valid).
- grant  output  NUM_REQ  one-hot of current grant; zero when idle.
- done  output  NUM_REQ  one-cycle pulse on bit i when burst for i completes.
- busy  output  1  high in SEND state.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; out_valid=0, out_sel=0, out_last=0, grant=0, done=0, busy=0, beat counter=0.
  - Reset mid-burst aborts immediately; no done pulse.
- FSM states:
  - IDLE: if any req bit is high at a clock edge, register winner index -> out_sel, winner one-hot -> grant, counter=0, go SEND. Otherwise stay.
  - SEND: out_valid=1, busy=1. On edge with out_valid && out_ready: if counter==BURST-1, pulse done[grant], clear grant/out_sel to 0, go IDLE; else counter++.
- Arbitration (default): fixed priority, lowest set index wins (casez-style `???1` ordering).
- Latency:
  - req sampled at edge k -> out_valid high after edge k.
  - Minimum one IDLE cycle between consecutive bursts, so the next out_valid comes at the edge after the final handshake + 1.
- req is sampled only in IDLE. Changes to req during SEND, including dropping the granted bit, are ignored and the burst runs to completion.
- out_last = (state==SEND) && (counter==BURST-1). It is combinational from registers and glitch-free.
- Backpressure: while out_valid && !out_ready, out_sel, out_last and the counter hold.
- BURST=1: out_last is high on the only beat.
- done is registered. It is high for exactly the cycle after the final handshake, coinciding with the IDLE cycle.
- Counter width is 4 bits and never wraps; it resets to 0 on each grant.
- Codes >= NUM_REQ are never emitted.

Optional Feature:
- Macro: STMT_SEL_BURST_ENCODER_RR_EN.
- Defined:
  - Round-robin arbitration. A registered last_idx holds the index of the last completed grant; reset value NUM_REQ-1.
  - Search order is last_idx+1, last_idx+2, ..., wrapping modulo NUM_REQ; first set bit wins.
  - last_idx updates only on burst completion, not on abort by reset.
- Undefined: fixed lowest-index priority as above; no last_idx register.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 2 cycles then high, req=3'b000 for 5 cycles.
  - Required: out_valid=0, grant=0, busy=0, done=0 throughout.
- Priority and burst, defaults, out_ready=1:
  - Stimulus: req=3'b110.
  - Required: out_sel=1 for 3 beats, out_last only on beat 3, grant=3'b010, done=3'b010 for one cycle, then IDLE gap.
  - Next burst: out_sel=1 again (fixed priority); with RR_EN the next burst is out_sel=2.
- Backpressure:
  - Stimulus: grant on code 0, out_ready low for 4 cycles on beat 2.
  - Required: out_sel=0 and out_last=0 held and counter frozen; resumes to complete exactly 3 handshakes.
- Request withdrawal:
  - Stimulus: req=3'b100 for one cycle then 0.
  - Required: full 3-beat burst with out_sel=2, done=3'b100.
- Async reset mid-burst:
  - Stimulus: rst_n low between beats 1 and 2 (asynchronous, mid-cycle).
  - Required: out_valid, grant and busy drop immediately; no done pulse; after release with req=3'b001 a fresh burst starts at counter 0.
- BURST=1, RR_EN defined:
  - Stimulus: req=3'b111 held.
  - Required: out_sel sequence 0,1,2,0 with out_last high on every beat and one IDLE cycle between each.
